// File: rtl/io_pkg.sv
// Shared definitions for the receive-side I/O words: widths, word types and
// the byte-to-word packing helper used by the input assembler.
package io_pkg;

    localparam int IO_WORD_W = 32;
    localparam int IO_BYTE_W = 8;

    typedef logic [IO_WORD_W-1:0]           io_word_t;
    typedef logic [IO_BYTE_W-1:0]           io_byte_t;
    typedef logic [IO_WORD_W-IO_BYTE_W-1:0] io_partial_t;

    // The partial register always holds the first byte in [7:0]; ordering is applied here.
    function automatic io_word_t io_pack_word(
        input io_partial_t partial,
        input io_byte_t    last_byte,
        input logic        big_endian
    );
        io_word_t word;
        if (big_endian) begin
            word = {partial[7:0], partial[15:8], partial[23:16], last_byte};
        end else begin
            word = {last_byte, partial};
        end
        return word;
    endfunction

endpackage

// File: rtl/io_word_fifo.sv
// Show-ahead synchronous word FIFO: head is read combinationally from the
// storage array at the read pointer; storage itself is never reset.
module io_word_fifo
    import io_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push,
    input  io_word_t            push_data,
    input  logic                pop,
    output io_word_t            head,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2+1)'(0);

    io_word_t              mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push_s, do_pop_s;

    // A push into a full FIFO succeeds only when a pop frees a slot on the same edge.
    always_comb begin
        do_pop_s  = pop & (count_q != CNT_ZERO);
        do_push_s = push & ((count_q != DEPTH_CNT) | do_pop_s);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= {DEPTH_LOG2{1'b0}};
            wr_ptr_q <= {DEPTH_LOG2{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == CNT_ZERO);

endmodule

// File: rtl/in_word_assembler.sv
// Packs UART bytes into 32-bit words for ININT/INFLT and queues them.
// Define IN_BIG_ENDIAN_EN to place the first received byte in [31:24].
module in_word_assembler
    import io_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_valid,
    input  logic [IO_BYTE_W-1:0]  rx_data,
    input  logic                  in_req,
    output logic [IO_WORD_W-1:0]  in_data,
    output logic                  in_busy,
    output logic [DEPTH_LOG2:0]   word_count,
    output logic                  overflow
);

`ifdef IN_BIG_ENDIAN_EN
    localparam logic BIG_ENDIAN = 1'b1;
`else
    localparam logic BIG_ENDIAN = 1'b0;
`endif

    logic [1:0]  bcnt_q, bcnt_d;
    io_partial_t partial_q, partial_d;
    logic        overflow_q, overflow_d;
    logic        push_s, pop_s;
    io_word_t    word_s;
    io_word_t    fifo_head_s;
    logic        fifo_full_s, fifo_empty_s;

    // Byte collection, word completion and the sticky drop flag.
    always_comb begin
        pop_s      = in_req & ~fifo_empty_s;
        push_s     = 1'b0;
        word_s     = io_pack_word(partial_q, rx_data, BIG_ENDIAN);
        bcnt_d     = bcnt_q;
        partial_d  = partial_q;
        overflow_d = overflow_q;
        if (rx_valid) begin
            if (bcnt_q == 2'd3) begin
                push_s    = 1'b1;
                bcnt_d    = 2'd0;
                partial_d = {(IO_WORD_W-IO_BYTE_W){1'b0}};
            end else begin
                bcnt_d = bcnt_q + 2'd1;
                case (bcnt_q)
                    2'd0:    partial_d[7:0]   = rx_data;
                    2'd1:    partial_d[15:8]  = rx_data;
                    2'd2:    partial_d[23:16] = rx_data;
                    default: partial_d        = partial_q;
                endcase
            end
        end else begin
            bcnt_d = bcnt_q;
        end
        if (push_s && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcnt_q     <= 2'd0;
            partial_q  <= {(IO_WORD_W-IO_BYTE_W){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            bcnt_q     <= bcnt_d;
            partial_q  <= partial_d;
            overflow_q <= overflow_d;
        end
    end

    io_word_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_s),
        .push_data (word_s),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (word_count),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign in_data  = fifo_head_s;
    assign in_busy  = fifo_empty_s;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_in_word_assembler.sv
// Self-checking bench for in_word_assembler: queue-based reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_in_word_assembler;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  in_req;
    logic [31:0]           in_data;
    logic                  in_busy;
    logic [DEPTH_LOG2:0]   word_count;
    logic                  overflow;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic [31:0] mq[$];
    logic [7:0]  mb[$];
    bit          movf = 1'b0;
    bit          m_popped;
    logic [31:0] m_word;

    in_word_assembler #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .in_req     (in_req),
        .in_data    (in_data),
        .in_busy    (in_busy),
        .word_count (word_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] compose(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0]  bs [4];
        logic [31:0] w;
        bs = '{b0, b1, b2, b3};
        w  = 32'h0;
        for (int i = 0; i < 4; i++) begin
`ifdef IN_BIG_ENDIAN_EN
            w[8*(3-i) +: 8] = bs[i];
`else
            w[8*i +: 8] = bs[i];
`endif
        end
        return w;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a word queue, a byte buffer and a sticky flag.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            mb.delete();
            movf = 1'b0;
        end else begin
            m_popped = in_req && (mq.size() != 0);
            if (rx_valid) begin
                mb.push_back(rx_data);
                if (mb.size() == 4) begin
                    m_word = compose(mb[0], mb[1], mb[2], mb[3]);
                    if (mq.size() < DEPTH || m_popped) mq.push_back(m_word);
                    else movf = 1'b1;
                    mb.delete();
                end
            end
            if (m_popped) void'(mq.pop_front());
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && rstn === 1'b1) begin
            check("in_busy", 32'(in_busy), 32'(mq.size() == 0));
            check("word_count", 32'(word_count), 32'(mq.size()));
            check("overflow", 32'(overflow), 32'(movf));
            if (mq.size() != 0) check("in_data", in_data, mq[0]);
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        rx_valid = v;
        rx_data  = d;
        in_req   = r;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        in_req   = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        drive(1'b1, b0, 1'b0);
        drive(1'b1, b1, 1'b0);
        drive(1'b1, b2, 1'b0);
        drive(1'b1, b3, 1'b0);
    endtask

    function automatic logic [31:0] fill_word(input int i);
        return compose(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48));
    endfunction

    initial begin
        int pprob;
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        in_req   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(in_busy), 32'd1);
        check("reset_count", 32'(word_count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        rstn   = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Basic assembly.
        send_word(8'h78, 8'h56, 8'h34, 8'h12);
        check("t1_busy", 32'(in_busy), 32'd0);
`ifdef IN_BIG_ENDIAN_EN
        check("t1_data", in_data, 32'h78563412);
`else
        check("t1_data", in_data, 32'h12345678);
`endif
        check("t1_count", 32'(word_count), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        check("t1_pop_busy", 32'(in_busy), 32'd1);

        // Full FIFO with simultaneous push and pop, then overflow.
        for (int i = 0; i < DEPTH; i++) send_word(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48));
        check("full_count", 32'(word_count), 32'd16);
        drive(1'b1, 8'hE0, 1'b0);
        drive(1'b1, 8'hE1, 1'b0);
        drive(1'b1, 8'hE2, 1'b0);
        drive(1'b1, 8'hE3, 1'b1);
        check("pp_overflow", 32'(overflow), 32'd0);
        check("pp_count", 32'(word_count), 32'd16);
        check("pp_head", in_data, fill_word(1));
        send_word(8'hF0, 8'hF1, 8'hF2, 8'hF3);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(word_count), 32'd16);
        check("ovf_head", in_data, fill_word(1));
        drive(1'b0, 8'h00, 1'b1);
        check("ovf_pop_head", in_data, fill_word(2));
        repeat (DEPTH) drive(1'b0, 8'h00, 1'b1);
        check("drain_busy", 32'(in_busy), 32'd1);

        // Empty FIFO: completing byte and request on the same edge.
        drive(1'b1, 8'hA1, 1'b0);
        drive(1'b1, 8'hA2, 1'b0);
        drive(1'b1, 8'hA3, 1'b0);
        drive(1'b1, 8'hA4, 1'b1);
        check("er_busy", 32'(in_busy), 32'd0);
        check("er_count", 32'(word_count), 32'd1);
        check("er_data", in_data, compose(8'hA1, 8'hA2, 8'hA3, 8'hA4));
        drive(1'b0, 8'h00, 1'b1);
        check("er_pop_busy", 32'(in_busy), 32'd1);

        // Reset mid-word discards partial bytes and the sticky flag.
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'hBB, 1'b0);
        #1 rstn = 1'b0;
        #1 check("rst_overflow", 32'(overflow), 32'd0);
        #1 rstn = 1'b1;
        @(negedge clk);
        send_word(8'h01, 8'h02, 8'h03, 8'h04);
`ifdef IN_BIG_ENDIAN_EN
        check("rst_data", in_data, 32'h01020304);
`else
        check("rst_data", in_data, 32'h04030201);
`endif
        check("rst_ovf_after", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1);

        // Requests while empty have no effect.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            check("idle_req_count", 32'(word_count), 32'd0);
        end
        send_word(8'h11, 8'h22, 8'h33, 8'h44);
        check("idle_req_data", in_data, compose(8'h11, 8'h22, 8'h33, 8'h44));

        // Randomized traffic with varying drain rate.
        for (int seg = 0; seg < 20; seg++) begin
            pprob = int'($urandom_range(0, 10)) * 10;
            if ($urandom_range(0, 3) == 0) begin
                #1 rstn = 1'b0;
                #1 rstn = 1'b1;
                @(negedge clk);
            end
            for (int c = 0; c < 200; c++) begin
                drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                      8'($urandom_range(0, 255)),
                      (int'($urandom_range(0, 99)) < pprob) ? 1'b1 : 1'b0);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/in_word_assembler.md
# in_word_assembler

Receive-side I/O block for the core's ININT/INFLT instructions. It collects the byte stream from the UART receiver into 32-bit words and holds them in a small FIFO. It presents the head word to the decode stage and drives `in_busy`, which the stall controller uses to freeze the PC while an input instruction waits for data. It acts as the responder to the pipeline's input requests.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO holds 2^DEPTH_LOG2 words.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `rx_valid`  in  1  one-cycle strobe, new byte on `rx_data`.
- `rx_data`  in  8  received byte.
- `in_req`  in  1  core consumes the head word this cycle (ININT/INFLT in decode, not stalled).
- `in_data`  out  32  head word of FIFO; valid only while `in_busy`=0.
- `in_busy`  out  1  high when no complete word is available (FIFO empty).
- `word_count`  out  DEPTH_LOG2+1  number of complete words stored.
- `overflow`  out  1  sticky; set when a completed word is dropped.

## Operation
- Byte assembly:
  - A 2-bit byte counter `bcnt` and a 24-bit partial register capture bytes 0..2.
  - On the 4th `rx_valid`, the word is formed from the partial register plus `rx_data` and pushed on the same edge.
  - `bcnt` wraps to 0 after the 4th byte.
- Byte order, without macro: little-endian. The first byte goes to [7:0] and the 4th to [31:24].
- FIFO: show-ahead. `in_data` = mem[rd_ptr] combinationally from the storage array; `in_busy` = (`word_count`==0).
- Pop:
  - Happens when `in_req` & ~`in_busy`.
  - `in_req` while `in_busy`=1 is ignored; it produces no error and no state change.
- Push/pop rules:
  - Full, with a push but no pop: the word is dropped, `overflow` is set, and `bcnt` still returns to 0.
  - Full, with push and pop in the same cycle: both succeed, and `word_count` is unchanged.
  - Empty, with push and `in_req` in the same cycle: the `in_req` is ignored because `in_busy` is high that cycle. The word becomes available next cycle.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. `word_count` saturates logically at 2^DEPTH_LOG2, since pushes are refused beyond that.
- `overflow` clears only on reset.

## Timing
- Reset values, applied asynchronously:
  - `bcnt`=0, partial=0, rd_ptr=wr_ptr=0.
  - `word_count`=0, `in_busy`=1, `overflow`=0.
  - `in_data` is undefined but is masked by `in_busy`. The storage array is not reset.
- Latency: 4th byte strobe at edge N → `in_busy` falls and `in_data` is valid in the cycle after edge N.
- Pop at edge N → the next word, if any, appears on `in_data` after edge N. `in_busy` rises after edge N if the FIFO became empty.
- Reset asserted mid-word discards the partial bytes. Reset mid-stream discards all stored words.
- `rx_valid` may arrive on consecutive cycles; every strobe is accepted.

## Configuration
- `IN_BIG_ENDIAN_EN` defined: the first byte goes to [31:24] and the 4th byte to [7:0].
- Undefined: little-endian as above.
- No other behaviour changes.

## Structure
- Shared package `io_pkg`:
  - `IO_WORD_W`=32 and `IO_BYTE_W`=8.
  - typedef `io_word_t` (logic [31:0]).
- One sub-module, `io_word_fifo`:
  - Show-ahead synchronous FIFO, parameterised on DEPTH_LOG2, with async active-low reset.
  - Ports: push, push_data, pop, head, count, full, empty.
  - The top module holds the byte assembler, the overflow flag and the `in_busy` mapping.

## Test plan
- Bytes 0x78,0x56,0x34,0x12, with no `in_req` → `in_busy`=0 and `in_data`=0x12345678 (0x78563412 with `IN_BIG_ENDIAN_EN`); `word_count`=1.
- Fill 16 words with no pops, then send 4 more bytes → `overflow`=1, `word_count`=16, and `in_data` is still word 0. Next `in_req` → word 1.
- FIFO full; the 4th byte of word 17 arrives in the same cycle as `in_req` → no overflow, `word_count`=16, and the head advances to word 1.
- Empty FIFO; the 4th byte and `in_req` in the same cycle → the request is ignored. Next cycle `in_busy`=0 with the word; a pop then leaves `in_busy`=1.
- Send 2 bytes, pulse `rstn` low mid-cycle, then send 0x01,0x02,0x03,0x04 → `in_data`=0x04030201 with no stale bytes, and `overflow`=0.
- `in_req` held high with `in_busy`=1 for 10 cycles → no pointer movement and `word_count` stays 0.
